// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage: bubble word,
// opcode/funct field positions and the fetch FSM state encoding.
package if_fetch_unit_pkg;

  localparam logic [31:0] BUBBLE_WORD = 32'hFC000000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and imem (slave).
// Handshake: the master raises imem_req with a word-aligned imem_addr and holds
// both stable until the cycle in which the slave pulses imem_rvalid (one cycle,
// at least one cycle after the request first appears) with imem_rdata.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from variable-latency imem and
// holds one instruction for IF/ID, honouring stalls and ID redirects.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] BUBBLE   = BUBBLE_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_IFIDWrite,
  input  logic                  c_redirect,
  input  logic [31:0]           redirect_pc,
  if_fetch_unit_if.master       imem,
  output logic                  fetch_valid,
  output logic [31:0]           instru_out,
  output logic [5:0]            ctr_out,
  output logic [5:0]            funcode_out,
  output logic [31:0]           nextpc_out,
  output fetch_state_t          state_dbg
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fa_q, fa_d;
  logic [31:0]  instru_q, nextpc_q;
  logic         valid_q, armed_q;
  logic         consume, outstanding, load;
  logic [31:0]  target;

  assign target  = {redirect_pc[31:2], 2'b00};
  assign consume = valid_q & c_IFIDWrite;

  // A request is only presented while the buffer is empty, so a response can
  // never arrive with nowhere to go; armed_q keeps the bus quiet during reset.
  assign outstanding = armed_q & (((state_q == ST_REQ) & ~valid_q) | (state_q == ST_DROP));
  assign load        = outstanding & imem.imem_rvalid & (state_q == ST_REQ) & ~c_redirect;

  assign imem.imem_req  = outstanding;
  assign imem.imem_addr = fa_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_REQ: begin
        if (c_redirect) begin
          pc_d = target;
          if (outstanding & ~imem.imem_rvalid) state_d = ST_DROP;
        end else if (load) begin
          pc_d = fa_q + 32'd4;
        end else if (valid_q & ~c_IFIDWrite) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (c_redirect) begin
          pc_d    = target;
          state_d = ST_REQ;
        end else if (consume) begin
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (c_redirect) pc_d = target;
        if (imem.imem_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
    // The fetch address follows the PC whenever a fresh request is about to begin.
    fa_d = (state_d == ST_REQ) ? pc_d : fa_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      fa_q     <= RESET_PC;
      armed_q  <= 1'b0;
      valid_q  <= 1'b0;
      instru_q <= BUBBLE;
      nextpc_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fa_q    <= fa_d;
      armed_q <= 1'b1;
      if (c_redirect || (consume && !load)) begin
        valid_q  <= 1'b0;
        instru_q <= BUBBLE;
        nextpc_q <= 32'd0;
      end else if (load) begin
        valid_q  <= 1'b1;
        instru_q <= imem.imem_rdata;
        nextpc_q <= fa_q + 32'd4;
      end
    end
  end

  assign fetch_valid = valid_q;
  assign instru_out  = instru_q;
  assign ctr_out     = instru_q[OP_MSB:OP_LSB];
  assign funcode_out = instru_q[FN_MSB:FN_LSB];
  assign nextpc_out  = nextpc_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle-level scenarios, then random stalls and
// redirects checked against a stream model of which word each consumed slot holds.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         c_IFIDWrite;
  logic         c_redirect;
  logic [31:0]  redirect_pc;
  logic         fetch_valid;
  logic [31:0]  instru_out;
  logic [5:0]   ctr_out;
  logic [5:0]   funcode_out;
  logic [31:0]  nextpc_out;
  fetch_state_t state_dbg;

  if_fetch_unit_if imem_bus();

  int n_checks = 0;
  int n_errors = 0;
  int mem_lat  = 1;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h00000000), .BUBBLE(32'hFC000000)) dut (
    .clk         (clk),
    .rst         (rst),
    .c_IFIDWrite (c_IFIDWrite),
    .c_redirect  (c_redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus),
    .fetch_valid (fetch_valid),
    .instru_out  (instru_out),
    .ctr_out     (ctr_out),
    .funcode_out (funcode_out),
    .nextpc_out  (nextpc_out),
    .state_dbg   (state_dbg)
  );

  // Memory contents: fixed word at 0, distinct odd-multiplier hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C010004;
    return (a * 32'h9E3779B1) + 32'h01234567;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic fv, input logic [31:0] w,
                           input logic [31:0] np);
    check_eq({tag, "_valid"},  {31'd0, fetch_valid}, {31'd0, fv});
    check_eq({tag, "_instr"},  instru_out, w);
    check_eq({tag, "_ctr"},    {26'd0, ctr_out}, {26'd0, w[31:26]});
    check_eq({tag, "_funct"},  {26'd0, funcode_out}, {26'd0, w[5:0]});
    check_eq({tag, "_nextpc"}, nextpc_out, np);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    while (fetch_valid !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check_eq({tag, "_in_time"}, {31'd0, fetch_valid}, 32'd1);
  endtask

  // ---------------- memory driver ----------------
  initial begin : mem_model
    logic        pending;
    int          cnt;
    logic [31:0] paddr;
    pending = 1'b0;
    cnt     = 0;
    paddr   = 32'h0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
    forever begin
      step();
      imem_bus.imem_rvalid = 1'b0;
      if (pending) begin
        if (rst !== 1'b1) begin
          check_eq("req_held", {31'd0, imem_bus.imem_req}, 32'd1);
          check_eq("addr_stable", imem_bus.imem_addr, paddr);
        end
        cnt--;
        if (cnt == 0) begin
          imem_bus.imem_rvalid = 1'b1;
          imem_bus.imem_rdata  = mem_word(paddr);
          pending = 1'b0;
        end
      end else if (imem_bus.imem_req === 1'b1) begin
        pending = 1'b1;
        paddr   = imem_bus.imem_addr;
        cnt     = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
      end
    end
  end

  // ---------------- directed then random stimulus ----------------
  initial begin : main
    logic        red;
    logic [31:0] tgt, a;
    int          gap, max_gap, consumed;

    rst = 1'b1; c_IFIDWrite = 1'b1; c_redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) step();
    check_out("reset", 1'b0, BUBBLE_WORD, 32'h0);
    check_eq("reset_req", {31'd0, imem_bus.imem_req}, 32'd0);
    rst = 1'b0;

    step();
    check_eq("first_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check_eq("first_addr", imem_bus.imem_addr, 32'h0);
    step();
    step();
    check_out("first_fetch", 1'b1, 32'h8C010004, 32'h4);

    // Stall with a full buffer: HOLD, bus idle, outputs frozen.
    c_IFIDWrite = 1'b0;
    repeat (3) begin
      step();
      check_eq("stall_state", 32'(state_dbg), 32'(ST_HOLD));
      check_eq("stall_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check_out("stall_hold", 1'b1, 32'h8C010004, 32'h4);
    end
    c_IFIDWrite = 1'b1;
    step();
    check_eq("release_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check_eq("release_addr", imem_bus.imem_addr, 32'h4);
    step();
    mem_lat = 3;
    step();
    check_out("second_fetch", 1'b1, mem_word(32'h4), 32'h8);

    // Redirect while a 3-cycle fetch at 8 is outstanding.
    step();
    check_eq("pre_drop_addr", imem_bus.imem_addr, 32'h8);
    c_redirect = 1'b1; redirect_pc = 32'h100;
    step();
    c_redirect = 1'b0;
    check_eq("drop_state", 32'(state_dbg), 32'(ST_DROP));
    repeat (3) begin
      check_eq("drop_req", {31'd0, imem_bus.imem_req}, 32'd1);
      check_eq("drop_addr", imem_bus.imem_addr, 32'h8);
      check_out("drop_bubble", 1'b0, BUBBLE_WORD, 32'h0);
      step();
    end
    check_out("drop_discard", 1'b0, BUBBLE_WORD, 32'h0);
    check_eq("drop_new_addr", imem_bus.imem_addr, 32'h100);
    c_IFIDWrite = 1'b0;
    wait_valid("drop_target", 8);
    check_out("drop_target", 1'b1, mem_word(32'h100), 32'h104);

    // Redirect while idle in HOLD.
    step();
    check_eq("hold_state", 32'(state_dbg), 32'(ST_HOLD));
    c_redirect = 1'b1; redirect_pc = 32'h40; mem_lat = 1;
    step();
    check_out("hold_redirect", 1'b0, BUBBLE_WORD, 32'h0);
    check_eq("hold_redirect_addr", imem_bus.imem_addr, 32'h40);

    // Unaligned redirect near the top of the address space, then wrap.
    redirect_pc = 32'hFFFFFFFF; c_IFIDWrite = 1'b1;
    step();
    c_redirect = 1'b0;
    check_eq("wrap_drop_state", 32'(state_dbg), 32'(ST_DROP));
    step();
    check_eq("wrap_addr", imem_bus.imem_addr, 32'hFFFFFFFC);
    wait_valid("wrap", 8);
    check_out("wrap_fetch", 1'b1, mem_word(32'hFFFFFFFC), 32'h0);
    mem_lat = 3;
    step();
    check_eq("wrap_next_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check_eq("wrap_next_addr", imem_bus.imem_addr, 32'h0);

    // Reset mid-request; the stale response lands while rst is high.
    rst = 1'b1;
    step();
    check_out("mid_reset", 1'b0, BUBBLE_WORD, 32'h0);
    check_eq("mid_reset_req", {31'd0, imem_bus.imem_req}, 32'd0);
    step();
    step();
    step();
    check_out("stale_ignored", 1'b0, BUBBLE_WORD, 32'h0);
    rst = 1'b0; mem_lat = 0;
    step();
    check_eq("post_reset_addr", imem_bus.imem_addr, 32'h0);
    check_eq("post_reset_req", {31'd0, imem_bus.imem_req}, 32'd1);

    // Random stalls/redirects: every consumed instruction must be the next word
    // of the current stream, and a redirect restarts the stream at its target.
    exp_q.delete();
    exp_q.push_back(32'h0);
    gap = 0; max_gap = 0; consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (fetch_valid !== 1'b1) check_out("idle_bubble", 1'b0, BUBBLE_WORD, 32'h0);
      c_IFIDWrite = ($urandom_range(0, 3) != 0);
      red = !c_redirect && ($urandom_range(0, 15) == 0);
      if (red) begin
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom_range(0, 4095));
        redirect_pc = tgt;
        exp_q.delete();
        exp_q.push_back({tgt[31:2], 2'b00});
        gap = 0;
      end else if (fetch_valid === 1'b1 && c_IFIDWrite) begin
        a = exp_q.pop_front();
        check_out("stream", 1'b1, mem_word(a), a + 32'd4);
        exp_q.push_back(a + 32'd4);
        consumed++;
        gap = 0;
      end else begin
        gap++;
      end
      if (gap > max_gap) max_gap = gap;
      c_redirect = red;
      step();
    end
    c_redirect = 1'b0;
    check_eq("liveness", {31'd0, (max_gap <= 30)}, 32'd1);
    check_eq("progress", {31'd0, (consumed >= 100)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
